eee_hsmooth: RTL and testbench
==============================

# eee_hsmooth

Streaming 3-tap horizontal smoothing filter, kernel [1 2 1]/4 per RGB channel, placed directly upstream of the image-processing/overlay stage in the camera video pipeline. It reduces sensor noise before colour-distance matching. It uses the same 24-bit RGB valid/ready/sop/eop packet stream on both sides. Control packets, non-video packets and bypass mode pass through unmodified.

## Interface
- IMAGE_W, 11'd640, pixels per video row; column counter wraps here
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous, active-low reset
- sink_data  in  24  {R,G,B}, R in [23:16]
- sink_valid  in  1  input word valid
- sink_ready  out  1  block accepts the word this cycle
- sink_sop / sink_eop  in  1  packet delimiters
- source_data  out  24  output word
- source_valid  out  1  output word valid
- source_ready  in  1  downstream accepts
- source_sop / source_eop  out  1  output delimiters
- mode  in  1  1 = filter video packets, 0 = bypass; sampled only on sop words

## Operation
- Accept = sink_valid & sink_ready. Emit = source_valid & source_ready.
- States:
  - IDLE: no packet active.
  - PASS: forward words.
  - FILT: filter pixels.
  - FLUSH: emit the last pixel of a row; no input accepted.
- Registers:
  - l, c: 24-bit left and centre pixels.
  - x: 11-bit column counter.
  - have: a centre pixel is held.
  - peop: pending eop.
- Sop word accepted in any accepting state:
  - Forwarded unchanged, with have cleared.
  - Next state is FILT if mode=1 and sink_data[3:0]==0; otherwise PASS.
  - x resets to 0.
  - A pixel held when the sop arrives is discarded.
- IDLE: non-sop words are forwarded unchanged.
- PASS: every word is forwarded unchanged. Eop returns the block to IDLE.
- FILT, accepted pixel p, when have=0:
  - l<=p, c<=p, have<=1.
  - No output this cycle.
- FILT, accepted pixel p, when have=1:
  - Emit (l + 2c + p)>>2 per channel, with sop=0 and eop=0.
  - Then l<=c, c<=p.
- FILT, accepted pixel with x==IMAGE_W-1 or eop=1:
  - After the above, go to FLUSH with peop<=eop.
  - x wraps to 0; otherwise x increments.
- FLUSH:
  - Emit (l + 3c)>>2 per channel, with eop=peop.
  - have<=0.
  - Next state is IDLE if peop, else FILT.
- Arithmetic:
  - Per channel, zero-extend to 10 bits, sum, truncate with >>2.
  - No rounding; overflow is impossible.
- Left edge replicates the first pixel. Right edge replicates the last pixel, which gives the FLUSH formula.
- A one-pixel row, or eop at x==0, gives FLUSH output equal to the input pixel.

## Timing
- Output register: source_* are registered. source_valid stays high and source_data/sop/eop stay stable until Emit.
- sink_ready = (state != FLUSH) & (~source_valid | source_ready). A word is accepted only when its output slot is free, so there is no data loss under backpressure.
- Latency:
  - Pass-through words and sop words: 1 cycle after accept.
  - Filtered column k: output 1 cycle after column k+1 is accepted. For the last column, output is 1 cycle after FLUSH.
- Throughput: 1 word/cycle, with exactly one stall cycle (sink_ready low in FLUSH) per filtered row.
- Reset values: source_valid=0, source_data=0, source_sop=0, source_eop=0, state=IDLE, have=0, x=0.
- sink_ready rises the first cycle after reset release.
- Reset mid-packet abandons the packet; no partial word is emitted.
- mode changes inside a packet have no effect until the next sop.

## Test plan
- Bypass: mode=0, sop word 0x000000, then pixels 0x102030 and 0x405060 with eop on the last. Output is identical and in order, each 1 cycle after accept.
- Filtered row: IMAGE_W=4, mode=1. Sop, then R=0,4,8,12 (G=B=0), eop on the last. Outputs are sop word, then R=1,4,8,11. eop is on R=11 only. sink_ready is low for exactly 1 cycle after the 4th pixel.
- Two rows: IMAGE_W=4, 8 pixels all 0x808080, eop on the 8th.
  - 8 outputs, all 0x808080.
  - FLUSH occurs after the 4th and 8th pixels.
  - eop is only on the 8th output.
- Non-video packet: mode=1, sop word 0x00000F, then 3 words. All are forwarded unchanged and no FLUSH stall occurs.
- Backpressure: filtered row with source_ready toggling 1-0-0-1 repeatedly.
  - Output sequence matches the no-backpressure case exactly.
  - source_data is stable while source_valid=1 and source_ready=0.
- Short packet and reset: sop plus a single pixel 0xFF0000 with eop gives output 0xFF0000 with eop. Then assert reset_n low mid-row: source_valid=0 immediately, and the next sop is handled normally.

Source files
------------

// File: rtl/eee_hsmooth.sv
// eee_hsmooth
//   Streaming 3-tap horizontal smoothing filter, kernel [1 2 1]/4 applied per
//   8-bit channel of a 24-bit {R,G,B} valid/ready/sop/eop packet stream.
//   Video packets (sop word low nibble == 0) are filtered when mode=1. Control
//   packets, non-video packets and bypass mode pass through unmodified.
//   Row edges replicate the first/last pixel of the row.
//
// Parameters
//   IMAGE_W      pixels per video row; the column counter wraps here
// Ports
//   clk          pipeline clock
//   reset_n      asynchronous active-low reset
//   sink_data    input word {R,G,B}, R in [23:16]
//   sink_valid   input word valid
//   sink_ready   block accepts the word this cycle
//   sink_sop     input start-of-packet
//   sink_eop     input end-of-packet
//   source_data  registered output word
//   source_valid output word valid
//   source_ready downstream accepts
//   source_sop   output start-of-packet
//   source_eop   output end-of-packet
//   mode         1 = filter video packets, 0 = bypass; sampled on sop words

module eee_hsmooth #(
  parameter logic [10:0] IMAGE_W = 11'd640
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] sink_data,
  input  logic        sink_valid,
  output logic        sink_ready,
  input  logic        sink_sop,
  input  logic        sink_eop,
  output logic [23:0] source_data,
  output logic        source_valid,
  input  logic        source_ready,
  output logic        source_sop,
  output logic        source_eop,
  input  logic        mode
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PASS  = 2'd1;
  localparam logic [1:0] S_FILT  = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [23:0] l_q, l_d;
  logic [23:0] c_q, c_d;
  logic [10:0] x_q, x_d;
  logic        have_q, have_d;
  logic        peop_q, peop_d;
  logic [23:0] src_data_q, src_data_d;
  logic        src_valid_q, src_valid_d;
  logic        src_sop_q, src_sop_d;
  logic        src_eop_q, src_eop_d;

  logic slot_free;
  logic accept;

  // (a + 2b + c) >> 2 per channel; the right-edge flush uses (l, c, c).
  function automatic logic [23:0] k121(input logic [23:0] a,
                                       input logic [23:0] b,
                                       input logic [23:0] c);
    logic [23:0] o;
    logic [9:0]  s;
    o = '0;
    for (int unsigned ch = 0; ch < 3; ch++) begin
      s = {2'b00, a[8*ch +: 8]} + {1'b0, b[8*ch +: 8], 1'b0} + {2'b00, c[8*ch +: 8]};
      o[8*ch +: 8] = s[9:2];
    end
    return o;
  endfunction

  assign slot_free  = ~src_valid_q | source_ready;
  assign sink_ready = (state_q != S_FLUSH) & slot_free;
  assign accept     = sink_valid & sink_ready;

  always_comb begin
    state_d     = state_q;
    l_d         = l_q;
    c_d         = c_q;
    x_d         = x_q;
    have_d      = have_q;
    peop_d      = peop_q;
    src_data_d  = src_data_q;
    src_valid_d = src_valid_q & ~source_ready;
    src_sop_d   = src_sop_q;
    src_eop_d   = src_eop_q;

    if (state_q == S_FLUSH) begin
      if (slot_free) begin
        src_valid_d = 1'b1;
        src_data_d  = k121(l_q, c_q, c_q);
        src_sop_d   = 1'b0;
        src_eop_d   = peop_q;
        have_d      = 1'b0;
        state_d     = peop_q ? S_IDLE : S_FILT;
      end
    end else if (accept) begin
      if (sink_sop) begin
        src_valid_d = 1'b1;
        src_data_d  = sink_data;
        src_sop_d   = 1'b1;
        src_eop_d   = sink_eop;
        have_d      = 1'b0;
        x_d         = '0;
        // A single-word packet is already complete, so nothing is left open.
        if (sink_eop)
          state_d = S_IDLE;
        else if (mode && (sink_data[3:0] == 4'h0))
          state_d = S_FILT;
        else
          state_d = S_PASS;
      end else begin
        case (state_q)
          S_IDLE, S_PASS: begin
            src_valid_d = 1'b1;
            src_data_d  = sink_data;
            src_sop_d   = 1'b0;
            src_eop_d   = sink_eop;
            if (sink_eop) state_d = S_IDLE;
          end
          S_FILT: begin
            if (!have_q) begin
              l_d    = sink_data;
              c_d    = sink_data;
              have_d = 1'b1;
            end else begin
              src_valid_d = 1'b1;
              src_data_d  = k121(l_q, c_q, sink_data);
              src_sop_d   = 1'b0;
              src_eop_d   = 1'b0;
              l_d         = c_q;
              c_d         = sink_data;
            end
            if ((x_q == IMAGE_W - 11'd1) || sink_eop) begin
              state_d = S_FLUSH;
              peop_d  = sink_eop;
              x_d     = '0;
            end else begin
              x_d = x_q + 11'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      l_q         <= '0;
      c_q         <= '0;
      x_q         <= '0;
      have_q      <= 1'b0;
      peop_q      <= 1'b0;
      src_data_q  <= '0;
      src_valid_q <= 1'b0;
      src_sop_q   <= 1'b0;
      src_eop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      l_q         <= l_d;
      c_q         <= c_d;
      x_q         <= x_d;
      have_q      <= have_d;
      peop_q      <= peop_d;
      src_data_q  <= src_data_d;
      src_valid_q <= src_valid_d;
      src_sop_q   <= src_sop_d;
      src_eop_q   <= src_eop_d;
    end
  end

  assign source_data  = src_data_q;
  assign source_valid = src_valid_q;
  assign source_sop   = src_sop_q;
  assign source_eop   = src_eop_q;

endmodule

// File: tb/tb_eee_hsmooth.sv
// tb_eee_hsmooth
//   Directed bench for eee_hsmooth with IMAGE_W=4. Expected output words are
//   queued as each packet is driven and compared in order as the DUT emits.

module tb_eee_hsmooth;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [23:0] sink_data;
  logic        sink_valid;
  logic        sink_ready;
  logic        sink_sop;
  logic        sink_eop;
  logic [23:0] source_data;
  logic        source_valid;
  logic        source_ready;
  logic        source_sop;
  logic        source_eop;
  logic        mode;

  int tests = 0;
  int fails = 0;
  int stall_cnt = 0;
  int stall_base;
  bit bp_en = 1'b0;

  logic [25:0] sb[$];          // {sop, eop, data}
  logic [23:0] rowbuf[8];

  always #5 clk = ~clk;

  eee_hsmooth #(.IMAGE_W(11'd4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sink_data    (sink_data),
    .sink_valid   (sink_valid),
    .sink_ready   (sink_ready),
    .sink_sop     (sink_sop),
    .sink_eop     (sink_eop),
    .source_data  (source_data),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .mode         (mode)
  );

  // Reference smoothing: integer arithmetic per channel.
  function automatic logic [23:0] ref_px(input logic [23:0] a,
                                         input logic [23:0] b,
                                         input logic [23:0] c);
    logic [23:0] o;
    int s;
    o = '0;
    for (int ch = 0; ch < 3; ch++) begin
      s = int'(a[8*ch +: 8]) + 2 * int'(b[8*ch +: 8]) + int'(c[8*ch +: 8]);
      o[8*ch +: 8] = 8'(s / 4);
    end
    return o;
  endfunction

  task automatic push(input logic [23:0] d, input logic s, input logic e);
    sb.push_back({s, e, d});
  endtask

  // Expected outputs for one row of n pixels taken from rowbuf[base..].
  task automatic push_row(input int base, input int n, input logic last_eop);
    logic [23:0] lft, ctr, rgt;
    for (int k = 0; k < n; k++) begin
      ctr = rowbuf[base + k];
      lft = (k == 0) ? ctr : rowbuf[base + k - 1];
      rgt = (k == n - 1) ? ctr : rowbuf[base + k + 1];
      push(ref_px(lft, ctr, rgt), 1'b0, last_eop && (k == n - 1));
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [23:0] d, input logic s, input logic e);
    bit ok;
    ok = 1'b0;
    sink_data  = d;
    sink_sop   = s;
    sink_eop   = e;
    sink_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (sink_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    sink_valid = 1'b0;
    check("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && (sb.size() != 0 || source_valid); i++) begin
      @(posedge clk);
      #1;
    end
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    reset_n      = 1'b0;
    sink_data    = '0;
    sink_valid   = 1'b0;
    sink_sop     = 1'b0;
    sink_eop     = 1'b0;
    mode         = 1'b0;
    source_ready = 1'b1;

    fork
      // Output monitor / scoreboard and hold-stability check.
      begin
        logic [25:0] exp_w;
        logic [25:0] held;
        bit          hold;
        hold = 1'b0;
        held = '0;
        forever begin
          @(negedge clk);
          if (reset_n && hold)
            check("hold_stable", {5'd0, source_valid, source_sop, source_eop, source_data},
                  {5'd0, 1'b1, held});
          hold = reset_n && source_valid && !source_ready;
          held = {source_sop, source_eop, source_data};
          if (reset_n && source_valid && source_ready) begin
            if (sb.size() == 0) begin
              check("unexpected_out", {6'd0, source_sop, source_eop, source_data}, 32'hFFFFFFFF);
            end else begin
              exp_w = sb.pop_front();
              check("out_word", {6'd0, source_sop, source_eop, source_data}, {6'd0, exp_w});
            end
          end
        end
      end
      // Downstream ready: always 1, or the 1-0-0-1 pattern when bp_en.
      begin
        int bi;
        bi = 0;
        forever begin
          @(posedge clk);
          #1;
          if (bp_en) begin
            source_ready = (bi == 0 || bi == 3);
            bi = (bi + 1) % 4;
          end else begin
            source_ready = 1'b1;
          end
        end
      end
      // Stall counter (sink_ready low with downstream ready).
      forever begin
        @(negedge clk);
        if (reset_n && !sink_ready && source_ready) stall_cnt++;
      end
      begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
      end
    join_none

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(source_valid), 32'd0);
    check("rst_data", 32'(source_data), 32'd0);
    check("rst_sop_eop", {30'd0, source_sop, source_eop}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready", 32'(sink_ready), 32'd1);

    // Bypass, one-cycle latency.
    mode = 1'b0;
    stall_base = stall_cnt;
    push(24'h000000, 1'b1, 1'b0);
    send(24'h000000, 1'b1, 1'b0);
    check("byp_lat0", {7'd0, source_valid, source_data}, {7'd0, 1'b1, 24'h000000});
    push(24'h102030, 1'b0, 1'b0);
    send(24'h102030, 1'b0, 1'b0);
    check("byp_lat1", {7'd0, source_valid, source_data}, {7'd0, 1'b1, 24'h102030});
    push(24'h405060, 1'b0, 1'b1);
    send(24'h405060, 1'b0, 1'b1);
    check("byp_lat2", {6'd0, source_valid, source_eop, source_data}, {6'd0, 2'b11, 24'h405060});
    drain("byp_drain");
    check("byp_stalls", 32'(stall_cnt - stall_base), 32'd0);

    // Filtered row R=0,4,8,12.
    mode = 1'b1;
    stall_base = stall_cnt;
    rowbuf[0] = 24'h000000; rowbuf[1] = 24'h040000;
    rowbuf[2] = 24'h080000; rowbuf[3] = 24'h0C0000;
    push(24'h000000, 1'b1, 1'b0);
    push_row(0, 4, 1'b1);
    send(24'h000000, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send(rowbuf[i], 1'b0, i == 3);
    check("flt_flush_stall", 32'(sink_ready), 32'd0);
    @(posedge clk);
    #1;
    check("flt_flush_done", 32'(sink_ready), 32'd1);
    drain("flt_drain");
    check("flt_stalls", 32'(stall_cnt - stall_base), 32'd1);

    // Two rows of 0x808080.
    stall_base = stall_cnt;
    for (int i = 0; i < 8; i++) rowbuf[i] = 24'h808080;
    push(24'h000000, 1'b1, 1'b0);
    push_row(0, 4, 1'b0);
    push_row(4, 4, 1'b1);
    send(24'h000000, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) send(rowbuf[i], 1'b0, i == 7);
    drain("two_drain");
    check("two_stalls", 32'(stall_cnt - stall_base), 32'd2);

    // Non-video packet with mode=1.
    stall_base = stall_cnt;
    push(24'h00000F, 1'b1, 1'b0);
    push(24'h111111, 1'b0, 1'b0);
    push(24'h222222, 1'b0, 1'b0);
    push(24'h333333, 1'b0, 1'b1);
    send(24'h00000F, 1'b1, 1'b0);
    send(24'h111111, 1'b0, 1'b0);
    send(24'h222222, 1'b0, 1'b0);
    send(24'h333333, 1'b0, 1'b1);
    drain("nv_drain");
    check("nv_stalls", 32'(stall_cnt - stall_base), 32'd0);

    // Filtered row under 1-0-0-1 backpressure, random pixels.
    for (int i = 0; i < 4; i++) rowbuf[i] = 24'($urandom);
    bp_en = 1'b1;
    push(24'h000000, 1'b1, 1'b0);
    push_row(0, 4, 1'b1);
    send(24'h000000, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send(rowbuf[i], 1'b0, i == 3);
    drain("bp_drain");
    bp_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // One-pixel packet.
    push(24'h000000, 1'b1, 1'b0);
    push(24'hFF0000, 1'b0, 1'b1);
    send(24'h000000, 1'b1, 1'b0);
    send(24'hFF0000, 1'b0, 1'b1);
    drain("short_drain");

    // Reset mid-row while column 0's result is waiting in the output register.
    rowbuf[0] = 24'h203040; rowbuf[1] = 24'h60A0C0;
    push(24'h000000, 1'b1, 1'b0);
    send(24'h000000, 1'b1, 1'b0);
    send(rowbuf[0], 1'b0, 1'b0);
    send(rowbuf[1], 1'b0, 1'b0);
    check("mid_col0", {7'd0, source_valid, source_data},
          {7'd0, 1'b1, ref_px(rowbuf[0], rowbuf[0], rowbuf[1])});
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(source_valid), 32'd0);
    check("mid_rst_data", {6'd0, source_sop, source_eop, source_data}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", 32'(sink_ready), 32'd1);
    push(24'hABCDEF, 1'b0, 1'b0);
    send(24'hABCDEF, 1'b0, 1'b0);
    rowbuf[0] = 24'h00FF00; rowbuf[1] = 24'h0000FF;
    push(24'h000000, 1'b1, 1'b0);
    push_row(0, 2, 1'b1);
    send(24'h000000, 1'b1, 1'b0);
    send(rowbuf[0], 1'b0, 1'b0);
    send(rowbuf[1], 1'b0, 1'b1);
    drain("post_rst_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
